// File: rtl/skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder_if
// Description : Bundle of the operand-A input stream and the skewed row-lane
//               outputs of the systolic-array skew feeder.
//               master : stream producer / output consumer (drives in_*)
//               slave  : the feeder itself (drives in_ready and all outputs)
//   in_valid   - in_data/in_last valid this cycle
//   in_ready   - feeder accepts a vector this cycle
//   in_data    - one column of operand A, slice i = element for row lane i
//   in_last    - final vector of the current tile (qualified by in_valid)
//   row_data   - skewed per-lane data, slice i drives array row i
//   row_valid  - per-lane data valid
//   array_ctrl - array activity flag (OR of row_valid)
//   tile_done  - one-cycle pulse when the tile has left lane N-1
//   vec_count  - vectors accepted in the current tile (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
interface skew_feeder_if #(
  parameter int N         = 4,
  parameter int bit_width = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N*bit_width-1:0]   in_data;
  logic                     in_last;
  logic [N*bit_width-1:0]   row_data;
  logic [N-1:0]             row_valid;
  logic                     array_ctrl;
  logic                     tile_done;
  logic [15:0]              vec_count;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, row_data, row_valid, array_ctrl, tile_done, vec_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, row_data, row_valid, array_ctrl, tile_done, vec_count
  );
endinterface
`default_nettype wire

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder
// Description : Feeds one column of operand A per cycle into the row lanes of
//               an N-row systolic array. Lane i delays its element by i+1
//               cycles so the array sees the classic diagonal wavefront.
//               After the last vector of a tile the feeder stalls input for N
//               cycles (DRAIN) so consecutive tiles never share the lanes.
// Ports       : clk   - single clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - skew_feeder_if.slave (input stream + lane outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module skew_feeder #(
  parameter int N         = 4,
  parameter int bit_width = 8
) (
  input wire          clk,
  input wire          reset,
  skew_feeder_if.slave bus
);

  localparam int C_CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_STREAM = 2'd1;
  localparam logic [1:0] C_DRAIN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [C_CW-1:0]        cnt_q, cnt_d;
  logic [15:0]            vec_count_q, vec_count_d;
  logic                   w_accept;
  logic                   w_in_ready;
  logic                   w_tile_done;
  logic [N*bit_width-1:0] w_row_data;
  logic [N-1:0]           w_row_valid;

  assign w_accept = bus.in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. The drain counter is loaded with N-1 on entry so DRAIN
  // spans exactly N cycles, i.e. until the last element leaves lane N-1.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE, C_STREAM: begin
        if (w_accept) begin
          if (bus.in_last) begin
            state_d = C_DRAIN;
            cnt_d   = C_CW'(N - 1);
          end else begin
            state_d = C_STREAM;
          end
        end
      end
      C_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = C_IDLE;
        end else begin
          cnt_d = cnt_q - C_CW'(1);
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = (state_q != C_DRAIN);
    w_tile_done = (state_q == C_DRAIN) && (cnt_q == '0);
  end

  // --------------------------------------------------------------------------
  // Vector counter: saturating, cleared right after tile_done. No accept can
  // coincide with tile_done because input is stalled during DRAIN.
  // --------------------------------------------------------------------------
  always_comb begin
    vec_count_d = vec_count_q;
    if (w_tile_done) begin
      vec_count_d = '0;
    end else if (w_accept && (vec_count_q != 16'hFFFF)) begin
      vec_count_d = vec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_count_q <= '0;
    end else begin
      vec_count_q <= vec_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Lane delay lines. Lane i has i+1 stages. Non-accept cycles inject a zero
  // element with valid 0, which keeps lane data zero whenever valid is low.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0][bit_width-1:0] dat_q, dat_d;
    logic [i:0]                vld_q, vld_d;

    always_comb begin
      dat_d    = '0;
      vld_d    = '0;
      dat_d[0] = w_accept ? bus.in_data[i*bit_width +: bit_width] : '0;
      vld_d[0] = w_accept;
      for (int k = 1; k <= i; k++) begin
        dat_d[k] = dat_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign w_row_data[i*bit_width +: bit_width] = dat_q[i];
    assign w_row_valid[i]                       = vld_q[i];
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.row_data   = w_row_data;
  assign bus.row_valid  = w_row_valid;
  assign bus.array_ctrl = |w_row_valid;
  assign bus.tile_done  = w_tile_done;
  assign bus.vec_count  = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_feeder
// Description : Directed self-checking bench for skew_feeder (N=4, 8-bit).
//               Inputs change and outputs are sampled on the falling edge;
//               "cycle c" is the period whose rising edge ends it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

  localparam int N  = 4;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  skew_feeder_if #(.N(N), .bit_width(BW)) bus ();

  skew_feeder #(.N(N), .bit_width(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check every output of the current cycle against hand-computed values.
  task automatic cyc(input string tag, input logic [31:0] d, input logic [3:0] v,
                     input logic rdy, input logic done, input logic [15:0] cnt);
    chk({tag, " row_data"},   bus.row_data,                d);
    chk({tag, " row_valid"},  {28'b0, bus.row_valid},      {28'b0, v});
    chk({tag, " in_ready"},   {31'b0, bus.in_ready},       {31'b0, rdy});
    chk({tag, " tile_done"},  {31'b0, bus.tile_done},      {31'b0, done});
    chk({tag, " vec_count"},  {16'b0, bus.vec_count},      {16'b0, cnt});
    chk({tag, " array_ctrl"}, {31'b0, bus.array_ctrl},     {31'b0, |v});
  endtask

  task automatic drive(input logic vld, input logic [31:0] data, input logic last);
    bus.in_valid = vld;
    bus.in_data  = data;
    bus.in_last  = last;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #2;
    cyc("reset", 32'h0, 4'b0000, 1'b1, 1'b0, 16'd0);

    // ---- single two-vector tile ----
    @(negedge clk); reset = 1'b1;
    cyc("t1c0", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0); drive(1'b1, 32'h04030201, 1'b0);
    @(negedge clk); cyc("t1c1", 32'h00000001, 4'b0001, 1'b1, 1'b0, 16'd1); drive(1'b1, 32'h08070605, 1'b1);
    @(negedge clk); cyc("t1c2", 32'h00000205, 4'b0011, 1'b0, 1'b0, 16'd2); drive(1'b0, 32'h0, 1'b0);
    @(negedge clk); cyc("t1c3", 32'h00030600, 4'b0110, 1'b0, 1'b0, 16'd2);
    @(negedge clk); cyc("t1c4", 32'h04070000, 4'b1100, 1'b0, 1'b0, 16'd2);
    @(negedge clk); cyc("t1c5", 32'h08000000, 4'b1000, 1'b0, 1'b1, 16'd2);
    @(negedge clk); cyc("t1c6", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);

    // ---- bubble; in_last without in_valid is ignored ----
    drive(1'b1, 32'h14131211, 1'b0);
    @(negedge clk); cyc("t2c1", 32'h00000011, 4'b0001, 1'b1, 1'b0, 16'd1); drive(1'b0, 32'hFFFFFFFF, 1'b1);
    @(negedge clk); cyc("t2c2", 32'h00001200, 4'b0010, 1'b1, 1'b0, 16'd1); drive(1'b1, 32'h24232221, 1'b1);
    @(negedge clk); cyc("t2c3", 32'h00130021, 4'b0101, 1'b0, 1'b0, 16'd2); drive(1'b0, 32'h0, 1'b0);
    @(negedge clk); cyc("t2c4", 32'h14002200, 4'b1010, 1'b0, 1'b0, 16'd2);
    @(negedge clk); cyc("t2c5", 32'h00230000, 4'b0100, 1'b0, 1'b0, 16'd2);
    @(negedge clk); cyc("t2c6", 32'h24000000, 4'b1000, 1'b0, 1'b1, 16'd2);
    @(negedge clk); cyc("t2c7", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);

    // ---- single-vector tile ----
    drive(1'b1, 32'h09090909, 1'b1);
    @(negedge clk); cyc("t3c1", 32'h00000009, 4'b0001, 1'b0, 1'b0, 16'd1); drive(1'b0, 32'h0, 1'b0);
    @(negedge clk); cyc("t3c2", 32'h00000900, 4'b0010, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t3c3", 32'h00090000, 4'b0100, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t3c4", 32'h09000000, 4'b1000, 1'b0, 1'b1, 16'd1);
    @(negedge clk); cyc("t3c5", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);

    // ---- back-to-back tiles, second held valid through DRAIN ----
    drive(1'b1, 32'h34333231, 1'b1);
    @(negedge clk); cyc("t4c1", 32'h00000031, 4'b0001, 1'b0, 1'b0, 16'd1); drive(1'b1, 32'h44434241, 1'b1);
    @(negedge clk); cyc("t4c2", 32'h00003200, 4'b0010, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t4c3", 32'h00330000, 4'b0100, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t4c4", 32'h34000000, 4'b1000, 1'b0, 1'b1, 16'd1);
    @(negedge clk); cyc("t4c5", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);
    @(negedge clk); cyc("t4c6", 32'h00000041, 4'b0001, 1'b0, 1'b0, 16'd1); drive(1'b0, 32'h0, 1'b0);
    @(negedge clk); cyc("t4c7", 32'h00004200, 4'b0010, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t4c8", 32'h00430000, 4'b0100, 1'b0, 1'b0, 16'd1);
    @(negedge clk); cyc("t4c9", 32'h44000000, 4'b1000, 1'b0, 1'b1, 16'd1);
    @(negedge clk); cyc("t4c10", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);

    // ---- asynchronous reset during STREAM with 3 lanes occupied ----
    drive(1'b1, 32'h54535251, 1'b0);
    @(negedge clk); cyc("t5c1", 32'h00000051, 4'b0001, 1'b1, 1'b0, 16'd1); drive(1'b1, 32'h64636261, 1'b0);
    @(negedge clk); cyc("t5c2", 32'h00005261, 4'b0011, 1'b1, 1'b0, 16'd2); drive(1'b1, 32'h74737271, 1'b0);
    @(negedge clk); cyc("t5c3", 32'h00536271, 4'b0111, 1'b1, 1'b0, 16'd3); drive(1'b0, 32'h0, 1'b0);
    #2; reset = 1'b0;
    #1; cyc("t5rst", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); cyc("t5post", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);
    end

    // ---- vec_count saturation, then a normal last ----
    for (int k = 0; k < 65540; k++) begin
      if (k == 65534) chk("t6 vec_count pre-sat", {16'b0, bus.vec_count}, 32'h0000FFFE);
      if (k == 65535) chk("t6 vec_count sat",     {16'b0, bus.vec_count}, 32'h0000FFFF);
      drive(1'b1, 32'h0, 1'b0);
      @(negedge clk);
    end
    cyc("t6c0", 32'h00000000, 4'b1111, 1'b1, 1'b0, 16'hFFFF); drive(1'b1, 32'h0A0A0A0A, 1'b1);
    @(negedge clk); cyc("t6c1", 32'h0000000A, 4'b1111, 1'b0, 1'b0, 16'hFFFF); drive(1'b0, 32'h0, 1'b0);
    @(negedge clk); cyc("t6c2", 32'h00000A00, 4'b1110, 1'b0, 1'b0, 16'hFFFF);
    @(negedge clk); cyc("t6c3", 32'h000A0000, 4'b1100, 1'b0, 1'b0, 16'hFFFF);
    @(negedge clk); cyc("t6c4", 32'h0A000000, 4'b1000, 1'b0, 1'b1, 16'hFFFF);
    @(negedge clk); cyc("t6c5", 32'h00000000, 4'b0000, 1'b1, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
